mult_seq: RTL and testbench

Sequential signed 16×16 multiplier responder: the device side of the req/ack/result_rdy multiplier protocol. It captures two parity-protected 16-bit signed operands on a request, acknowledges them, and computes the product with a radix-2 Booth datapath, one iteration per clock. It returns a 32-bit signed result with even parity, or flags an argument parity error. It sits directly under the test bench driver, which is the protocol initiator.

---
 rtl/mult_seq_if.sv | 25 ++
 rtl/mult_seq.sv | 133 +++++++++++++
 tb/tb_mult_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// Request/acknowledge/result bundle for the sequential signed multiplier.
// The initiator drives the operands and request; the responder returns
// the acknowledge, product and status.
interface mult_seq_if;
    logic        req;
    logic [15:0] arg_a;
    logic        arg_a_parity;
    logic [15:0] arg_b;
    logic        arg_b_parity;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        arg_parity_error;
    logic        result_rdy;

    modport master (
        output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
        input  ack, result, result_parity, arg_parity_error, result_rdy
    );

    modport slave (
        input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
        output ack, result, result_parity, arg_parity_error, result_rdy
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential signed 16x16 multiplier responder. Operands are captured on a
// request, parity-checked, and multiplied with a radix-2 Booth datapath that
// retires one multiplier bit per clock. All outputs are registered.
module mult_seq (
    input  logic     clk,
    input  logic     rst_n,
    mult_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] mcand_reg;     // multiplicand A
    logic [16:0] acc_reg;       // one guard bit so +/-(-32768) never overflows
    logic [15:0] q_reg;         // multiplier B, shifted out LSB first
    logic        qm1_reg;       // Booth Q-1 bit
    logic        perr_reg;      // captured operand parity failure

    logic        ack_reg;
    logic        rdy_reg;
    logic [31:0] result_reg;
    logic        result_parity_reg;
    logic        arg_parity_error_reg;

    logic [16:0] mcand_ext;
    logic [16:0] sum_next;
    logic [33:0] shift_next;    // {acc, q, q-1} after add and arithmetic shift
    logic [31:0] product_next;
    logic        start;

    // Booth step: add/subtract the multiplicand, then shift {acc,q,q-1} right
    always_comb begin
        mcand_ext = {mcand_reg[15], mcand_reg};
        sum_next  = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   sum_next = acc_reg + mcand_ext;
            2'b10:   sum_next = acc_reg - mcand_ext;
            default: sum_next = acc_reg;
        endcase
        shift_next   = {sum_next[16], sum_next, q_reg};
        product_next = shift_next[32:1];
    end

    // A request is accepted in IDLE, and also on the edge that ends the
    // result_rdy pulse, so a held request restarts without a dead cycle.
    always_comb begin
        start = bus.req && ((state_reg == IDLE) || ((state_reg == DONE) && rdy_reg));
    end

    // Control FSM, Booth datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            cnt_reg              <= 4'd0;
            mcand_reg            <= 16'd0;
            acc_reg              <= 17'd0;
            q_reg                <= 16'd0;
            qm1_reg              <= 1'b0;
            perr_reg             <= 1'b0;
            ack_reg              <= 1'b0;
            rdy_reg              <= 1'b0;
            result_reg           <= 32'd0;
            result_parity_reg    <= 1'b0;
            arg_parity_error_reg <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    rdy_reg <= 1'b0;
                end
                ACK: begin
                    cnt_reg <= 4'd0;
                    if (perr_reg) begin
                        // No multiplication; DONE spends one extra cycle
                        // before the result_rdy pulse on this path.
                        result_reg           <= 32'd0;
                        result_parity_reg    <= 1'b0;
                        arg_parity_error_reg <= 1'b1;
                        rdy_reg              <= 1'b0;
                        state_reg            <= DONE;
                    end else begin
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= shift_next[33:17];
                    q_reg   <= shift_next[16:1];
                    qm1_reg <= shift_next[0];
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        result_reg           <= product_next;
                        result_parity_reg    <= ^product_next;
                        arg_parity_error_reg <= 1'b0;
                        rdy_reg              <= 1'b1;
                        state_reg            <= DONE;
                    end
                end
                DONE: begin
                    if (!rdy_reg) begin
                        rdy_reg <= 1'b1;
                    end else begin
                        rdy_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Operand capture overrides the state update above
            if (start) begin
                mcand_reg <= bus.arg_a;
                q_reg     <= bus.arg_b;
                acc_reg   <= 17'd0;
                qm1_reg   <= 1'b0;
                perr_reg  <= (^bus.arg_a ^ bus.arg_a_parity) |
                             (^bus.arg_b ^ bus.arg_b_parity);
                ack_reg   <= 1'b1;
                state_reg <= ACK;
            end
        end
    end

    assign bus.ack              = ack_reg;
    assign bus.result_rdy       = rdy_reg;
    assign bus.result           = result_reg;
    assign bus.result_parity    = result_parity_reg;
    assign bus.arg_parity_error = arg_parity_error_reg;
endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: protocol timing, Booth products on corner
// operands, parity-error path, back-to-back requests and mid-run reset.
module tb_mult_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mult_seq_if bus();

    mult_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; the first posedge is T0. After T0 the operands are
    // replaced by na/nb (correct parity) and req is left at 'hold'.
    // Returns when result_rdy is seen or the cycle budget expires.
    task automatic run_txn(input logic [15:0] a, input logic pa,
                           input logic [15:0] b, input logic pb,
                           input logic [15:0] na, input logic [15:0] nb,
                           input logic hold,
                           output int ack_edge, output int ack_len, output int rdy_edge,
                           output logic [31:0] res, output logic rp, output logic pe);
        int e;
        ack_edge = -1;
        ack_len  = 0;
        rdy_edge = -1;
        res      = 'x;
        rp       = 1'bx;
        pe       = 1'bx;
        bus.arg_a        = a;
        bus.arg_a_parity = pa;
        bus.arg_b        = b;
        bus.arg_b_parity = pb;
        bus.req          = 1'b1;
        e = 0;
        while (rdy_edge < 0 && e < 30) begin
            @(posedge clk);
            #1;
            if (bus.ack === 1'b1) begin
                if (ack_edge < 0) ack_edge = e;
                ack_len++;
            end
            if (bus.result_rdy === 1'b1) begin
                rdy_edge = e;
                res = bus.result;
                rp  = bus.result_parity;
                pe  = bus.arg_parity_error;
            end
            if (e == 0) begin
                bus.req          = hold;
                bus.arg_a        = na;
                bus.arg_a_parity = ^na;
                bus.arg_b        = nb;
                bus.arg_b_parity = ^nb;
            end
            e++;
        end
        $display("txn a=%h b=%h ack_edge=%0d rdy_edge=%0d result=%h parity=%b perr=%b",
                 a, b, ack_edge, rdy_edge, res, rp, pe);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 1'b0;
        bus.arg_a = 16'h0;
        bus.arg_a_parity = 1'b0;
        bus.arg_b = 16'h0;
        bus.arg_b_parity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", bus.ack); end
        n_cmp++; if (bus.result_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got=%b want=0", bus.result_rdy); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
        n_cmp++; if (bus.result_parity !== 1'b0) begin n_bad++; $display("FAIL reset_parity got=%b want=0", bus.result_parity); end
        n_cmp++; if (bus.arg_parity_error !== 1'b0) begin n_bad++; $display("FAIL reset_perr got=%b want=0", bus.arg_parity_error); end
    endtask

    // Reset released together with req=1: first edge captures 3 x -5
    task automatic test_basic();
        int ae, al, re;
        logic [31:0] res;
        logic rp, pe;
        rst_n = 1'b1;
        run_txn(16'd3, 1'b0, 16'hFFFB, 1'b1, 16'h1234, 16'h4321, 1'b0, ae, al, re, res, rp, pe);
        n_cmp++; if (ae !== 0) begin n_bad++; $display("FAIL basic_ack_edge got=%0d want=0", ae); end
        n_cmp++; if (al !== 1) begin n_bad++; $display("FAIL basic_ack_len got=%0d want=1", al); end
        n_cmp++; if (re !== 17) begin n_bad++; $display("FAIL basic_rdy_edge got=%0d want=17", re); end
        n_cmp++; if (res !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL basic_result got=%h want=fffffff1", res); end
        n_cmp++; if (rp !== 1'b1) begin n_bad++; $display("FAIL basic_parity got=%b want=1", rp); end
        n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL basic_perr got=%b want=0", pe); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.result_rdy !== 1'b0) begin n_bad++; $display("FAIL basic_rdy_width got=%b want=0", bus.result_rdy); end
        n_cmp++; if (bus.result !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL basic_result_hold got=%h want=fffffff1", bus.result); end
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL basic_no_ack got=%b want=0", bus.ack); end
    endtask

    task automatic test_corners();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic [31:0] tr [3];
        logic        tp [3];
        int ae, al, re;
        logic [31:0] res;
        logic rp, pe;
        ta[0] = 16'h8000; tb[0] = 16'h8000; tr[0] = 32'h40000000; tp[0] = 1'b1;
        ta[1] = 16'h7FFF; tb[1] = 16'h8000; tr[1] = 32'hC0008000; tp[1] = 1'b1;
        ta[2] = 16'h0000; tb[2] = 16'hFFFF; tr[2] = 32'h00000000; tp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_txn(ta[i], ^ta[i], tb[i], ^tb[i], 16'hBEEF, 16'h0F0F, 1'b0, ae, al, re, res, rp, pe);
            n_cmp++; if (re !== 17) begin n_bad++; $display("FAIL corner%0d_rdy_edge got=%0d want=17", i, re); end
            n_cmp++; if (res !== tr[i]) begin n_bad++; $display("FAIL corner%0d_result got=%h want=%h", i, res, tr[i]); end
            n_cmp++; if (rp !== tp[i]) begin n_bad++; $display("FAIL corner%0d_parity got=%b want=%b", i, rp, tp[i]); end
            n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL corner%0d_perr got=%b want=0", i, pe); end
        end
    endtask

    task automatic test_parity_error();
        int ae, al, re;
        logic [31:0] res;
        logic rp, pe;
        run_txn(16'd3, 1'b1, 16'd2, 1'b1, 16'h5555, 16'h0001, 1'b0, ae, al, re, res, rp, pe);
        n_cmp++; if (ae !== 0) begin n_bad++; $display("FAIL perr_ack_edge got=%0d want=0", ae); end
        n_cmp++; if (al !== 1) begin n_bad++; $display("FAIL perr_ack_len got=%0d want=1", al); end
        n_cmp++; if (re !== 2) begin n_bad++; $display("FAIL perr_rdy_edge got=%0d want=2", re); end
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL perr_result got=%h want=0", res); end
        n_cmp++; if (rp !== 1'b0) begin n_bad++; $display("FAIL perr_parity got=%b want=0", rp); end
        n_cmp++; if (pe !== 1'b1) begin n_bad++; $display("FAIL perr_flag got=%b want=1", pe); end
        // Next request sampled at T3, the edge that ends result_rdy
        run_txn(16'd3, 1'b0, 16'd2, 1'b1, 16'h1111, 16'h2222, 1'b0, ae, al, re, res, rp, pe);
        n_cmp++; if (ae !== 0) begin n_bad++; $display("FAIL perr_next_ack_edge got=%0d want=0", ae); end
        n_cmp++; if (res !== 32'd6) begin n_bad++; $display("FAIL perr_next_result got=%h want=6", res); end
        n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL perr_clear got=%b want=0", pe); end
        n_cmp++; if (rp !== 1'b0) begin n_bad++; $display("FAIL perr_next_parity got=%b want=0", rp); end
    endtask

    task automatic test_back_to_back();
        int ae, al, re, e, rdy2;
        logic [31:0] res;
        logic rp, pe;
        // First: 100 x -3, operands switch to 7 x 9 during CALC, req held
        run_txn(16'd100, 1'b1, 16'hFFFD, 1'b1, 16'd7, 16'd9, 1'b1, ae, al, re, res, rp, pe);
        n_cmp++; if (re !== 17) begin n_bad++; $display("FAIL b2b_first_rdy_edge got=%0d want=17", re); end
        n_cmp++; if (res !== 32'hFFFFFED4) begin n_bad++; $display("FAIL b2b_first_result got=%h want=fffffed4", res); end
        n_cmp++; if (rp !== 1'b1) begin n_bad++; $display("FAIL b2b_first_parity got=%b want=1", rp); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL b2b_second_ack_t18 got=%b want=1", bus.ack); end
        bus.req          = 1'b0;
        bus.arg_a        = 16'h1234;
        bus.arg_a_parity = ^bus.arg_a;
        bus.arg_b        = 16'h1111;
        bus.arg_b_parity = ^bus.arg_b;
        rdy2 = -1;
        e = 1;
        while (rdy2 < 0 && e < 30) begin
            @(posedge clk);
            #1;
            if (bus.result_rdy === 1'b1) begin
                rdy2 = e;
                res  = bus.result;
                rp   = bus.result_parity;
            end
            e++;
        end
        $display("txn a=0007 b=0009 rdy_edge=%0d result=%h parity=%b", rdy2, res, rp);
        n_cmp++; if (rdy2 !== 17) begin n_bad++; $display("FAIL b2b_second_rdy_edge got=%0d want=17", rdy2); end
        n_cmp++; if (res !== 32'd63) begin n_bad++; $display("FAIL b2b_second_result got=%h want=3f", res); end
        n_cmp++; if (rp !== 1'b0) begin n_bad++; $display("FAIL b2b_second_parity got=%b want=0", rp); end
    endtask

    task automatic test_reset_mid();
        int ae, al, re, rdy_seen;
        logic [31:0] res;
        logic rp, pe;
        // Leave a nonzero, odd-parity result behind first
        run_txn(16'd3, 1'b0, 16'hFFFB, 1'b1, 16'h0, 16'h0, 1'b0, ae, al, re, res, rp, pe);
        @(posedge clk);
        #1;
        // 1000 x 1000, reset after the 8th CALC cycle
        bus.arg_a = 16'd1000; bus.arg_a_parity = 1'b0;
        bus.arg_b = 16'd1000; bus.arg_b_parity = 1'b0;
        bus.req   = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got=%h want=0", bus.result); end
        n_cmp++; if (bus.result_parity !== 1'b0) begin n_bad++; $display("FAIL rstmid_parity got=%b want=0", bus.result_parity); end
        n_cmp++; if (bus.result_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy got=%b want=0", bus.result_rdy); end
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack got=%b want=0", bus.ack); end
        n_cmp++; if (bus.arg_parity_error !== 1'b0) begin n_bad++; $display("FAIL rstmid_perr got=%b want=0", bus.arg_parity_error); end
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_rdy === 1'b1 || bus.ack === 1'b1) rdy_seen++;
        end
        n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse got=%0d want=0", rdy_seen); end
        run_txn(16'd7, 1'b1, 16'd7, 1'b1, 16'h0, 16'h0, 1'b0, ae, al, re, res, rp, pe);
        n_cmp++; if (re !== 17) begin n_bad++; $display("FAIL rstmid_fresh_rdy_edge got=%0d want=17", re); end
        n_cmp++; if (res !== 32'd49) begin n_bad++; $display("FAIL rstmid_fresh_result got=%h want=31", res); end
        n_cmp++; if (rp !== 1'b1) begin n_bad++; $display("FAIL rstmid_fresh_parity got=%b want=1", rp); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_corners();
        test_parity_error();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
